rs_multi_cdb: RTL and testbench

- Parametrised reservation station for the out-of-order RV32I core. Sits between decoder/ROB issue and the ALU.
- Holds RS_DEPTH entries and snoops CDB_N result buses for operand wakeup, including same-cycle capture on issue.
- Dispatches the oldest ready entry to the ALU through a valid/ready handshake.
- Supports full flush on ROB misprediction clear-up.

---
 rtl/rs_pkg.sv | 31 +++
 rtl/rs_multi_cdb_if.sv | 53 +++++
 rtl/rs_age_select.sv | 20 ++
 rtl/rs_multi_cdb.sv | 168 ++++++++++++++++
 tb/tb_rs_multi_cdb.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared types for the reservation station: op-type codes, default widths
// and the per-entry record.
package rs_pkg;

    localparam int DEF_ROB_BITS = 4;
    localparam int DEF_XLEN     = 32;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    typedef struct packed {
        logic                    busy;
        logic [6:0]              op_type;
        logic [2:0]              funct3;
        logic                    funct7b5;
        logic [DEF_XLEN-1:0]     pc;
        logic [DEF_XLEN-1:0]     v1;
        logic [DEF_XLEN-1:0]     v2;
        logic                    pend1;
        logic                    pend2;
        logic [DEF_ROB_BITS-1:0] q1;
        logic [DEF_ROB_BITS-1:0] q2;
        logic [DEF_ROB_BITS-1:0] rd_rob;
    } rs_entry_t;

endpackage

// File: rtl/rs_multi_cdb_if.sv
// Issue, CDB snoop and ALU dispatch bundle of the reservation station.
// master = issue/CDB/ALU side, slave = the station itself.
interface rs_multi_cdb_if
    import rs_pkg::*;
#(
    parameter int ROB_BITS = DEF_ROB_BITS,
    parameter int XLEN     = DEF_XLEN,
    parameter int CDB_N    = 2
);
    logic                      issue_valid;
    logic [6:0]                issue_op_type;
    logic [2:0]                issue_funct3;
    logic                      issue_funct7b5;
    logic [XLEN-1:0]           issue_pc;
    logic [XLEN-1:0]           issue_v1;
    logic [XLEN-1:0]           issue_v2;
    logic                      issue_q1_pend;
    logic                      issue_q2_pend;
    logic [ROB_BITS-1:0]       issue_q1;
    logic [ROB_BITS-1:0]       issue_q2;
    logic [ROB_BITS-1:0]       issue_rd_rob;
    logic                      full_out;
    logic [CDB_N-1:0]          cdb_valid;
    logic [CDB_N*ROB_BITS-1:0] cdb_rob;
    logic [CDB_N*XLEN-1:0]     cdb_value;
    logic                      alu_ready_in;
    logic                      disp_valid;
    logic [6:0]                disp_op_type;
    logic [2:0]                disp_funct3;
    logic                      disp_funct7b5;
    logic [XLEN-1:0]           disp_v1;
    logic [XLEN-1:0]           disp_v2;
    logic [XLEN-1:0]           disp_pc;
    logic [ROB_BITS-1:0]       disp_rob;

    modport master (
        output issue_valid, issue_op_type, issue_funct3, issue_funct7b5,
        output issue_pc, issue_v1, issue_v2, issue_q1_pend, issue_q2_pend,
        output issue_q1, issue_q2, issue_rd_rob,
        output cdb_valid, cdb_rob, cdb_value, alu_ready_in,
        input  full_out, disp_valid, disp_op_type, disp_funct3,
        input  disp_funct7b5, disp_v1, disp_v2, disp_pc, disp_rob
    );

    modport slave (
        input  issue_valid, issue_op_type, issue_funct3, issue_funct7b5,
        input  issue_pc, issue_v1, issue_v2, issue_q1_pend, issue_q2_pend,
        input  issue_q1, issue_q2, issue_rd_rob,
        input  cdb_valid, cdb_rob, cdb_value, alu_ready_in,
        output full_out, disp_valid, disp_op_type, disp_funct3,
        output disp_funct7b5, disp_v1, disp_v2, disp_pc, disp_rob
    );
endinterface

// File: rtl/rs_age_select.sv
// Oldest-ready picker over an age matrix: age[j][i]=1 means j is older than i.
module rs_age_select #(
    parameter int RS_DEPTH = 8
) (
    input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age,
    input  logic [RS_DEPTH-1:0]               ready,
    output logic [RS_DEPTH-1:0]               grant,
    output logic                              valid
);
    // The diagonal is held at zero, so an entry never blocks itself.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (ready[j] && age[j][i]) grant[i] = 1'b0;
            end
        end
        valid = |ready;
    end
endmodule

// File: rtl/rs_multi_cdb.sv
// Reservation station with multi-channel CDB wakeup and oldest-first dispatch.
// Optional RS_PERF_EN adds issue/dispatch/full-cycle counters.
module rs_multi_cdb
    import rs_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int ROB_BITS = DEF_ROB_BITS,
    parameter int CDB_N    = 2,
    parameter int XLEN     = DEF_XLEN
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush_in,
    rs_multi_cdb_if.slave   bus
`ifdef RS_PERF_EN
    ,
    output logic [XLEN-1:0] perf_issue_cnt,
    output logic [XLEN-1:0] perf_disp_cnt,
    output logic [XLEN-1:0] perf_full_cnt
`endif
);
    localparam int IDX_W = $clog2(RS_DEPTH);

    rs_entry_t ent_q [RS_DEPTH];
    rs_entry_t ent_d [RS_DEPTH];
    rs_entry_t nw;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;
    logic [RS_DEPTH-1:0] busy, ready, grant;
    logic gnt_valid, full, do_issue, do_disp;
    logic [IDX_W-1:0] free_idx, gnt_idx;
    logic [XLEN:0] s1, s2, w1, w2;

    // Returns {hit, value}; the lowest matching channel wins.
    function automatic logic [XLEN:0] snoop(
        input logic [ROB_BITS-1:0]       tag,
        input logic [CDB_N-1:0]          cv,
        input logic [CDB_N*ROB_BITS-1:0] cr,
        input logic [CDB_N*XLEN-1:0]     cd
    );
        snoop = '0;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (cv[k] && cr[k*ROB_BITS +: ROB_BITS] == tag)
                snoop = {1'b1, cd[k*XLEN +: XLEN]};
        end
    endfunction

    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            busy[i]  = ent_q[i].busy;
            ready[i] = ent_q[i].busy && !ent_q[i].pend1 && !ent_q[i].pend2;
            if (!ent_q[i].busy) free_idx = IDX_W'(i);
        end
    end

    rs_age_select #(.RS_DEPTH(RS_DEPTH)) u_sel (
        .age   (age_q),
        .ready (ready),
        .grant (grant),
        .valid (gnt_valid)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) gnt_idx = IDX_W'(i);
        end
    end

    assign full         = &busy;
    assign bus.full_out = full;
    assign do_issue     = bus.issue_valid && !full;
    assign do_disp      = gnt_valid && bus.alu_ready_in;

    always_comb begin
        s1 = snoop(bus.issue_q1, bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
        s2 = snoop(bus.issue_q2, bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
        nw.busy     = 1'b1;
        nw.op_type  = bus.issue_op_type;
        nw.funct3   = bus.issue_funct3;
        nw.funct7b5 = bus.issue_funct7b5;
        nw.pc       = bus.issue_pc;
        nw.pend1    = bus.issue_q1_pend && !s1[XLEN];
        nw.pend2    = bus.issue_q2_pend && !s2[XLEN];
        nw.v1       = (bus.issue_q1_pend && s1[XLEN]) ? s1[XLEN-1:0] : bus.issue_v1;
        nw.v2       = (bus.issue_q2_pend && s2[XLEN]) ? s2[XLEN-1:0] : bus.issue_v2;
        nw.q1       = bus.issue_q1;
        nw.q2       = bus.issue_q2;
        nw.rd_rob   = bus.issue_rd_rob;
    end

    always_comb begin
        age_d = age_q;
        w1 = '0;
        w2 = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            w1 = snoop(ent_q[i].q1, bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
            w2 = snoop(ent_q[i].q2, bus.cdb_valid, bus.cdb_rob, bus.cdb_value);
            if (ent_q[i].pend1 && w1[XLEN]) begin
                ent_d[i].pend1 = 1'b0;
                ent_d[i].v1    = w1[XLEN-1:0];
            end
            if (ent_q[i].pend2 && w2[XLEN]) begin
                ent_d[i].pend2 = 1'b0;
                ent_d[i].v2    = w2[XLEN-1:0];
            end
            if (do_disp && grant[i]) ent_d[i].busy = 1'b0;
        end
        // New entry is younger than everything currently busy.
        if (do_issue) begin
            ent_d[free_idx] = nw;
            for (int j = 0; j < RS_DEPTH; j++) begin
                age_d[free_idx][j] = 1'b0;
                age_d[j][free_idx] = busy[j];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
            age_q             <= '0;
            bus.disp_valid    <= 1'b0;
            bus.disp_op_type  <= '0;
            bus.disp_funct3   <= '0;
            bus.disp_funct7b5 <= 1'b0;
            bus.disp_v1       <= '0;
            bus.disp_v2       <= '0;
            bus.disp_pc       <= '0;
            bus.disp_rob      <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                for (int i = 0; i < RS_DEPTH; i++) ent_q[i].busy <= 1'b0;
                bus.disp_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
                age_q          <= age_d;
                bus.disp_valid <= do_disp;
                if (do_disp) begin
                    bus.disp_op_type  <= ent_q[gnt_idx].op_type;
                    bus.disp_funct3   <= ent_q[gnt_idx].funct3;
                    bus.disp_funct7b5 <= ent_q[gnt_idx].funct7b5;
                    bus.disp_v1       <= ent_q[gnt_idx].v1;
                    bus.disp_v2       <= ent_q[gnt_idx].v2;
                    bus.disp_pc       <= ent_q[gnt_idx].pc;
                    bus.disp_rob      <= ent_q[gnt_idx].rd_rob;
                end
            end
        end
    end

`ifdef RS_PERF_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_issue_cnt <= '0;
            perf_disp_cnt  <= '0;
            perf_full_cnt  <= '0;
        end else if (rdy_in) begin
            if (!flush_in && do_issue) perf_issue_cnt <= perf_issue_cnt + 1'b1;
            if (!flush_in && do_disp)  perf_disp_cnt  <= perf_disp_cnt + 1'b1;
            if (full)                  perf_full_cnt  <= perf_full_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Bench for rs_multi_cdb: directed scenarios plus random traffic against
// an in-order queue model of the station.
module tb_rs_multi_cdb;
    import rs_pkg::*;

    localparam int D  = 8;
    localparam int RB = 4;
    localparam int XL = 32;
    localparam int CN = 2;

    logic clk = 1'b0;
    logic rst, rdy, flush;

    rs_multi_cdb_if #(.ROB_BITS(RB), .XLEN(XL), .CDB_N(CN)) ifc ();

`ifdef RS_PERF_EN
    logic [XL-1:0] p_iss, p_dsp, p_full;
`endif

    rs_multi_cdb #(.RS_DEPTH(D), .ROB_BITS(RB), .CDB_N(CN), .XLEN(XL)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .rdy_in   (rdy),
        .flush_in (flush),
        .bus      (ifc)
`ifdef RS_PERF_EN
        ,
        .perf_issue_cnt (p_iss),
        .perf_disp_cnt  (p_dsp),
        .perf_full_cnt  (p_full)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] pc, v1, v2;
        logic        p1, p2;
        logic [3:0]  q1, q2, rob;
    } ment_t;

    ment_t mq[$];
    logic [111:0] exp_b;
    logic exp_full;
    int checks = 0;
    int errors = 0;
    wire [111:0] got_b = {ifc.disp_valid, ifc.disp_op_type, ifc.disp_funct3,
                          ifc.disp_funct7b5, ifc.disp_v1, ifc.disp_v2,
                          ifc.disp_pc, ifc.disp_rob};

    function automatic logic [32:0] snoop_m(input logic [3:0] tag);
        for (int k = 0; k < CN; k++) begin
            if (ifc.cdb_valid[k] && ifc.cdb_rob[k*RB +: RB] == tag)
                return {1'b1, ifc.cdb_value[k*XL +: XL]};
        end
        return '0;
    endfunction

    // One clock of the station described as a FIFO of entries in issue order.
    task automatic model();
        int sel;
        bit was_full;
        ment_t e;
        logic [32:0] h;
        if (!rdy) return;
        if (flush) begin
            mq.delete();
            exp_b[111] = 1'b0;
            exp_full = 1'b0;
            return;
        end
        was_full = (mq.size() == D);
        sel = -1;
        if (ifc.alu_ready_in) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].p1 && !mq[i].p2) begin
                    sel = i;
                    break;
                end
            end
        end
        if (sel >= 0)
            exp_b = {1'b1, mq[sel].op, mq[sel].f3, mq[sel].f7, mq[sel].v1,
                     mq[sel].v2, mq[sel].pc, mq[sel].rob};
        else
            exp_b[111] = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
            h = snoop_m(mq[i].q1);
            if (mq[i].p1 && h[32]) begin mq[i].p1 = 1'b0; mq[i].v1 = h[31:0]; end
            h = snoop_m(mq[i].q2);
            if (mq[i].p2 && h[32]) begin mq[i].p2 = 1'b0; mq[i].v2 = h[31:0]; end
        end
        if (sel >= 0) mq.delete(sel);
        if (ifc.issue_valid && !was_full) begin
            e.op = ifc.issue_op_type; e.f3 = ifc.issue_funct3;
            e.f7 = ifc.issue_funct7b5; e.pc = ifc.issue_pc;
            e.q1 = ifc.issue_q1; e.q2 = ifc.issue_q2; e.rob = ifc.issue_rd_rob;
            e.v1 = ifc.issue_v1; e.v2 = ifc.issue_v2;
            e.p1 = ifc.issue_q1_pend; e.p2 = ifc.issue_q2_pend;
            h = snoop_m(e.q1);
            if (e.p1 && h[32]) begin e.p1 = 1'b0; e.v1 = h[31:0]; end
            h = snoop_m(e.q2);
            if (e.p2 && h[32]) begin e.p2 = 1'b0; e.v2 = h[31:0]; end
            mq.push_back(e);
        end
        exp_full = (mq.size() == D);
    endtask

    task automatic step();
        model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc.issue_valid = 1'b0;
        ifc.cdb_valid   = '0;
        flush = 1'b0;
        rdy   = 1'b1;
    endtask

    task automatic put(input logic [31:0] v1, input logic [31:0] v2,
                       input logic p1, input logic [3:0] q1,
                       input logic p2, input logic [3:0] q2,
                       input logic [3:0] rob);
        ifc.issue_valid    = 1'b1;
        ifc.issue_op_type  = OP_ALU;
        ifc.issue_funct3   = rob[2:0];
        ifc.issue_funct7b5 = rob[0];
        ifc.issue_pc       = 32'h1000 + {26'd0, rob, 2'b00};
        ifc.issue_v1 = v1; ifc.issue_v2 = v2;
        ifc.issue_q1_pend = p1; ifc.issue_q1 = q1;
        ifc.issue_q2_pend = p2; ifc.issue_q2 = q2;
        ifc.issue_rd_rob = rob;
    endtask

    task automatic cdb(input logic [1:0] v, input logic [3:0] t0, input logic [3:0] t1,
                       input logic [31:0] d0, input logic [31:0] d1);
        ifc.cdb_valid = v;
        ifc.cdb_rob   = {t1, t0};
        ifc.cdb_value = {d1, d0};
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        ifc.alu_ready_in = 1'b0;
        put('0, '0, 1'b0, '0, 1'b0, '0, '0);
        idle();
        cdb(2'b00, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got_b !== '0 || ifc.full_out !== 1'b0) begin
            errors++;
            $display("FAIL reset got %h full %b req 0 full 0", got_b, ifc.full_out);
        end
        mq.delete(); exp_b = '0; exp_full = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        ifc.alu_ready_in = 1'b1;
        put(32'd5, 32'd7, 1'b0, '0, 1'b0, '0, 4'd3);
        step();
        idle();
        checks++;
        if (got_b !== exp_b || ifc.disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_e1 got %h req %h", got_b, exp_b);
        end
        step();
        checks++;
        if (got_b !== exp_b || ifc.disp_valid !== 1'b1 || ifc.disp_v1 !== 32'd5 ||
            ifc.disp_v2 !== 32'd7 || ifc.disp_rob !== 4'd3) begin
            errors++;
            $display("FAIL basic_e2 got %h req %h (v1=5 v2=7 rob=3)", got_b, exp_b);
        end
        step();
        checks++;
        if (got_b !== exp_b || ifc.disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse got %h req %h", got_b, exp_b);
        end
    endtask

    task automatic test_cdb_wakeup();
        put(32'd0, 32'd1, 1'b1, 4'd2, 1'b0, '0, 4'd4);
        step();
        idle();
        cdb(2'b10, 4'd0, 4'd2, 32'h0, 32'hDEAD);
        step();
        checks++;
        if (got_b !== exp_b || ifc.disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wake_edge got %h req %h", got_b, exp_b);
        end
        idle();
        step();
        checks++;
        if (got_b !== exp_b || ifc.disp_valid !== 1'b1 || ifc.disp_v1 !== 32'hDEAD) begin
            errors++;
            $display("FAIL wake_disp got %h req %h (v1=dead)", got_b, exp_b);
        end
    endtask

    task automatic test_same_cycle();
        put(32'd11, 32'd0, 1'b0, '0, 1'b1, 4'd6, 4'd5);
        cdb(2'b01, 4'd6, 4'd0, 32'd9, 32'd0);
        step();
        idle();
        step();
        checks++;
        if (got_b !== exp_b || ifc.disp_valid !== 1'b1 || ifc.disp_v2 !== 32'd9 ||
            ifc.disp_rob !== 4'd5) begin
            errors++;
            $display("FAIL same_cycle got %h req %h (v2=9)", got_b, exp_b);
        end
    endtask

    task automatic test_full_order();
        ifc.alu_ready_in = 1'b0;
        for (int i = 0; i < D; i++) begin
            put(32'd0, 32'(i), 1'b1, 4'(i), 1'b0, '0, 4'(i));
            step();
        end
        idle();
        checks++;
        if (ifc.full_out !== 1'b1 || exp_full !== 1'b1) begin
            errors++;
            $display("FAIL full_set got %b req 1", ifc.full_out);
        end
        cdb(2'b11, 4'd5, 4'd2, 32'h55, 32'h22);
        ifc.alu_ready_in = 1'b1;
        step();
        idle();
        checks++;
        if (got_b !== exp_b || ifc.full_out !== 1'b1 || ifc.disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_wake got %h full %b req %h full 1", got_b, ifc.full_out, exp_b);
        end
        step();
        checks++;
        if (got_b !== exp_b || ifc.disp_rob !== 4'd2 || ifc.disp_v1 !== 32'h22 ||
            ifc.full_out !== 1'b0) begin
            errors++;
            $display("FAIL order_first got %h full %b req %h rob 2 full 0",
                     got_b, ifc.full_out, exp_b);
        end
        step();
        checks++;
        if (got_b !== exp_b || ifc.disp_valid !== 1'b1 || ifc.disp_rob !== 4'd5) begin
            errors++;
            $display("FAIL order_second got %h req %h rob 5", got_b, exp_b);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        step();
        idle();
        ifc.alu_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(32'(i + 100), 32'd1, 1'b0, '0, 1'b0, '0, 4'(i + 8));
            step();
        end
        ifc.alu_ready_in = 1'b1;
        flush = 1'b1;
        put(32'd77, 32'd1, 1'b0, '0, 1'b0, '0, 4'd15);
        step();
        idle();
        checks++;
        if (got_b !== exp_b || ifc.disp_valid !== 1'b0 || ifc.full_out !== 1'b0) begin
            errors++;
            $display("FAIL flush got %h req %h", got_b, exp_b);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (got_b !== exp_b || ifc.disp_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_quiet cyc %0d got %h req %h", c, got_b, exp_b);
            end
        end
    endtask

    task automatic test_rdy_freeze();
        logic [111:0] held;
        ifc.alu_ready_in = 1'b1;
        put(32'd0, 32'd2, 1'b1, 4'd3, 1'b0, '0, 4'd9);
        step();
        put(32'd1, 32'd2, 1'b0, '0, 1'b0, '0, 4'd7);
        step();
        idle();
        step();
        held = got_b;
        checks++;
        if (got_b !== exp_b || ifc.disp_rob !== 4'd7 || ifc.disp_valid !== 1'b1) begin
            errors++;
            $display("FAIL freeze_pre got %h req %h", got_b, exp_b);
        end
        for (int c = 0; c < 3; c++) begin
            rdy = 1'b0;
            cdb(2'b01, 4'd3, 4'd0, 32'h333, 32'h0);
            step();
            checks++;
            if (got_b !== exp_b || got_b !== held) begin
                errors++;
                $display("FAIL freeze_hold cyc %0d got %h req %h", c, got_b, held);
            end
        end
        idle();
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (got_b !== exp_b || ifc.disp_valid !== 1'b0) begin
                errors++;
                $display("FAIL freeze_nowake cyc %0d got %h req %h", c, got_b, exp_b);
            end
        end
        cdb(2'b01, 4'd3, 4'd0, 32'h333, 32'h0);
        step();
        idle();
        step();
        checks++;
        if (got_b !== exp_b || ifc.disp_v1 !== 32'h333 || ifc.disp_rob !== 4'd9) begin
            errors++;
            $display("FAIL freeze_late got %h req %h", got_b, exp_b);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 49) == 0);
            ifc.alu_ready_in   = ($urandom_range(0, 3) != 0);
            ifc.issue_valid    = $urandom_range(0, 1);
            ifc.issue_op_type  = $urandom_range(0, 1) ? OP_ALU : OP_ALUI;
            ifc.issue_funct3   = 3'($urandom);
            ifc.issue_funct7b5 = 1'($urandom);
            ifc.issue_pc       = $urandom;
            ifc.issue_v1       = $urandom;
            ifc.issue_v2       = $urandom;
            ifc.issue_q1_pend  = ($urandom_range(0, 2) == 0);
            ifc.issue_q2_pend  = ($urandom_range(0, 2) == 0);
            ifc.issue_q1       = 4'($urandom_range(0, 7));
            ifc.issue_q2       = 4'($urandom_range(0, 7));
            ifc.issue_rd_rob   = 4'($urandom);
            cdb(2'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                $urandom, $urandom);
            step();
            checks++;
            if (got_b !== exp_b || ifc.full_out !== exp_full) begin
                errors++;
                $display("FAIL random cyc %0d got %h full %b req %h full %b",
                         c, got_b, ifc.full_out, exp_b, exp_full);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        flush = 1'b1;
        step();
        idle();
        ifc.alu_ready_in = 1'b1;
        put(32'd42, 32'd43, 1'b0, '0, 1'b0, '0, 4'd1);
        step();
        idle();
        step();
        checks++;
        if (got_b !== exp_b || ifc.disp_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre got %h req %h", got_b, exp_b);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (got_b !== '0 || ifc.full_out !== 1'b0) begin
            errors++;
            $display("FAIL arst_now got %h full %b req 0", got_b, ifc.full_out);
        end
        mq.delete(); exp_b = '0; exp_full = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (got_b !== exp_b || ifc.disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_post got %h req %h", got_b, exp_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cdb_wakeup();
        test_same_cycle();
        test_full_order();
        test_flush();
        test_rdy_freeze();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
